// File: rtl/can_frame_rx_monitor_if.sv
// Bit-strobe input and decoded-frame output bundle of the CAN frame rx monitor.
// The monitor is the slave side; the bench drives the bus as master.
interface can_frame_rx_monitor_if #(
  parameter int CNT_W = 16
) ();
  logic             bit_en;
  logic             rxbit;
  logic             frame_valid;
  logic [10:0]      rx_id;
  logic             rx_rtr;
  logic [3:0]       rx_dlc;
  logic [63:0]      rx_data;
  logic             stuff_err;
  logic             crc_err;
  logic             form_err;
  logic             busy;
  logic [CNT_W-1:0] frame_count;
  logic [CNT_W-1:0] err_count;

  modport slave (
    input  bit_en, rxbit,
    output frame_valid, rx_id, rx_rtr, rx_dlc, rx_data,
    output stuff_err, crc_err, form_err, busy,
    output frame_count, err_count
  );

  modport master (
    output bit_en, rxbit,
    input  frame_valid, rx_id, rx_rtr, rx_dlc, rx_data,
    input  stuff_err, crc_err, form_err, busy,
    input  frame_count, err_count
  );
endinterface

// File: rtl/can_frame_rx_monitor.sv
// Standard-frame CAN receiver: destuff, parse, CRC-15 and form checks.
// Define CANRX_ACK_CHECK_EN to require a dominant ACK slot.
module can_frame_rx_monitor #(
  parameter int IDLE_BITS = 11,
  parameter int CNT_W     = 16
) (
  input logic                   clk,
  input logic                   rst,
  can_frame_rx_monitor_if.slave bus
);
  localparam int IW = $clog2(IDLE_BITS + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_BITS);
  localparam logic [IW-1:0] IDLE_PRE = IW'(IDLE_BITS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ARB, S_CTRL, S_DATA, S_CRC,
    S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_ERROR
  } state_t;

  function automatic logic [14:0] crc_step(
    input logic [14:0] c, input logic b);
    crc_step = {c[13:0], 1'b0} ^
               ((b ^ c[14]) ? 15'h4599 : 15'h0000);
  endfunction

  state_t           state_q, state_d;
  logic [IW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [6:0]       bit_cnt_q, bit_cnt_d;
  logic [2:0]       run_cnt_q, run_cnt_d;
  logic             last_bit_q, last_bit_d;
  logic [14:0]      crc_q, crc_d;
  logic [14:0]      crc_rx_q, crc_rx_d;
  logic [10:0]      id_q, id_d;
  logic             rtr_q, rtr_d;
  logic [3:0]       dlc_q, dlc_d;
  logic [3:0]       len_q, len_d;
  logic [63:0]      data_q, data_d;
  logic             fv_q, fv_d;
  logic [10:0]      rx_id_q, rx_id_d;
  logic             rx_rtr_q, rx_rtr_d;
  logic [3:0]       rx_dlc_q, rx_dlc_d;
  logic [63:0]      rx_data_q, rx_data_d;
  logic             se_q, se_d;
  logic             ce_q, ce_d;
  logic             fe_q, fe_d;
  logic [CNT_W-1:0] frame_count_q, frame_count_d;
  logic [CNT_W-1:0] err_count_q, err_count_d;

  logic       rxb;
  logic       take;
  logic       err_s, err_c, err_f;
  logic [3:0] dlc_n;
  logic [3:0] len_n;
  logic [6:0] nbits;

  assign rxb   = bus.rxbit;
  assign nbits = {len_q, 3'b000};

  always_comb begin
    state_d       = state_q;
    idle_cnt_d    = idle_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    run_cnt_d     = run_cnt_q;
    last_bit_d    = last_bit_q;
    crc_d         = crc_q;
    crc_rx_d      = crc_rx_q;
    id_d          = id_q;
    rtr_d         = rtr_q;
    dlc_d         = dlc_q;
    len_d         = len_q;
    data_d        = data_q;
    rx_id_d       = rx_id_q;
    rx_rtr_d      = rx_rtr_q;
    rx_dlc_d      = rx_dlc_q;
    rx_data_d     = rx_data_q;
    frame_count_d = frame_count_q;
    err_count_d   = err_count_q;
    fv_d          = 1'b0;
    se_d          = 1'b0;
    ce_d          = 1'b0;
    fe_d          = 1'b0;
    take          = 1'b1;
    err_s         = 1'b0;
    err_c         = 1'b0;
    err_f         = 1'b0;
    dlc_n         = {dlc_q[2:0], rxb};
    len_n         = 4'd0;
    if (bus.bit_en) begin
      // Destuffing window spans SOF through the last CRC bit.
      if (state_q inside {S_ARB, S_CTRL, S_DATA, S_CRC}) begin
        if (run_cnt_q == 3'd5) begin
          take = 1'b0;
          if (rxb == last_bit_q) begin
            err_s = 1'b1;
          end else begin
            run_cnt_d  = 3'd1;
            last_bit_d = rxb;
          end
        end else begin
          run_cnt_d  = (rxb == last_bit_q) ? run_cnt_q + 3'd1 : 3'd1;
          last_bit_d = rxb;
        end
      end
      if (take) begin
        unique case (state_q)
          S_IDLE: begin
            if (rxb) begin
              if (idle_cnt_q != IDLE_MAX)
                idle_cnt_d = idle_cnt_q + 1'b1;
            end else if (idle_cnt_q == IDLE_MAX) begin
              state_d    = S_ARB;
              bit_cnt_d  = 7'd0;
              run_cnt_d  = 3'd1;
              last_bit_d = 1'b0;
              crc_d      = 15'd0;
              crc_rx_d   = 15'd0;
              id_d       = 11'd0;
              rtr_d      = 1'b0;
              dlc_d      = 4'd0;
              len_d      = 4'd0;
              data_d     = 64'd0;
            end else begin
              idle_cnt_d = '0;
            end
          end
          S_ARB: begin
            crc_d = crc_step(crc_q, rxb);
            if (bit_cnt_q < 7'd11) begin
              id_d      = {id_q[9:0], rxb};
              bit_cnt_d = bit_cnt_q + 7'd1;
            end else begin
              rtr_d     = rxb;
              state_d   = S_CTRL;
              bit_cnt_d = 7'd0;
            end
          end
          S_CTRL: begin
            crc_d = crc_step(crc_q, rxb);
            if (bit_cnt_q == 7'd0 && rxb) begin
              err_f = 1'b1;
            end else if (bit_cnt_q == 7'd5) begin
              dlc_d = dlc_n;
              if (!rtr_q)
                len_n = (dlc_n > 4'd8) ? 4'd8 : dlc_n;
              len_d     = len_n;
              state_d   = (len_n == 4'd0) ? S_CRC : S_DATA;
              bit_cnt_d = 7'd0;
            end else begin
              if (bit_cnt_q >= 7'd2)
                dlc_d = dlc_n;
              bit_cnt_d = bit_cnt_q + 7'd1;
            end
          end
          S_DATA: begin
            crc_d = crc_step(crc_q, rxb);
            data_d[6'd63 - bit_cnt_q[5:0]] = rxb;
            if (bit_cnt_q == nbits - 7'd1) begin
              state_d   = S_CRC;
              bit_cnt_d = 7'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + 7'd1;
            end
          end
          S_CRC: begin
            crc_rx_d = {crc_rx_q[13:0], rxb};
            if (bit_cnt_q == 7'd14) begin
              state_d   = S_CRC_DEL;
              bit_cnt_d = 7'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + 7'd1;
            end
          end
          S_CRC_DEL: begin
            if (!rxb)                 err_f   = 1'b1;
            else if (crc_rx_q != crc_q) err_c = 1'b1;
            else                      state_d = S_ACK;
          end
          S_ACK: begin
`ifdef CANRX_ACK_CHECK_EN
            if (rxb) err_f   = 1'b1;
            else     state_d = S_ACK_DEL;
`else
            state_d = S_ACK_DEL;
`endif
          end
          S_ACK_DEL: begin
            if (!rxb) begin
              err_f = 1'b1;
            end else begin
              state_d   = S_EOF;
              bit_cnt_d = 7'd0;
            end
          end
          S_EOF: begin
            if (!rxb) begin
              err_f = 1'b1;
            end else if (bit_cnt_q == 7'd6) begin
              rx_id_d       = id_q;
              rx_rtr_d      = rtr_q;
              rx_dlc_d      = dlc_q;
              rx_data_d     = data_q;
              fv_d          = 1'b1;
              frame_count_d = frame_count_q + CNT_W'(1);
              state_d       = S_IDLE;
              idle_cnt_d    = IDLE_MAX;
            end else begin
              bit_cnt_d = bit_cnt_q + 7'd1;
            end
          end
          S_ERROR: begin
            if (!rxb) begin
              idle_cnt_d = '0;
            end else if (idle_cnt_q == IDLE_PRE) begin
              state_d    = S_IDLE;
              idle_cnt_d = IDLE_MAX;
            end else begin
              idle_cnt_d = idle_cnt_q + 1'b1;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
      if (err_s || err_c || err_f) begin
        se_d        = err_s;
        ce_d        = err_c;
        fe_d        = err_f;
        err_count_d = err_count_q + CNT_W'(1);
        state_d     = S_ERROR;
        idle_cnt_d  = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idle_cnt_q    <= IDLE_MAX;
      bit_cnt_q     <= '0;
      run_cnt_q     <= '0;
      last_bit_q    <= 1'b1;
      crc_q         <= '0;
      crc_rx_q      <= '0;
      id_q          <= '0;
      rtr_q         <= 1'b0;
      dlc_q         <= '0;
      len_q         <= '0;
      data_q        <= '0;
      fv_q          <= 1'b0;
      rx_id_q       <= '0;
      rx_rtr_q      <= 1'b0;
      rx_dlc_q      <= '0;
      rx_data_q     <= '0;
      se_q          <= 1'b0;
      ce_q          <= 1'b0;
      fe_q          <= 1'b0;
      frame_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      idle_cnt_q    <= idle_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      run_cnt_q     <= run_cnt_d;
      last_bit_q    <= last_bit_d;
      crc_q         <= crc_d;
      crc_rx_q      <= crc_rx_d;
      id_q          <= id_d;
      rtr_q         <= rtr_d;
      dlc_q         <= dlc_d;
      len_q         <= len_d;
      data_q        <= data_d;
      fv_q          <= fv_d;
      rx_id_q       <= rx_id_d;
      rx_rtr_q      <= rx_rtr_d;
      rx_dlc_q      <= rx_dlc_d;
      rx_data_q     <= rx_data_d;
      se_q          <= se_d;
      ce_q          <= ce_d;
      fe_q          <= fe_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

  assign bus.frame_valid = fv_q;
  assign bus.rx_id       = rx_id_q;
  assign bus.rx_rtr      = rx_rtr_q;
  assign bus.rx_dlc      = rx_dlc_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.stuff_err   = se_q;
  assign bus.crc_err     = ce_q;
  assign bus.form_err    = fe_q;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_ERROR);
  assign bus.frame_count = frame_count_q;
  assign bus.err_count   = err_count_q;
endmodule
